data_sram_responder: RTL and testbench

//  Slave end of the CPU data-SRAM port: serves the en/we/addr/wdata requests from the EX stage.

---
 rtl/dsram_pkg.sv | 23 ++
 rtl/dsram_mmio_regs.sv | 80 ++++++++
 rtl/data_sram_responder.sv | 74 +++++++
 tb/tb_data_sram_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsram_pkg.sv
// Shared definitions for the data-SRAM responder: MMIO register offsets,
// CMP reset value and the read/write request encoding.
package dsram_pkg;

  localparam logic [15:0] OFF_LED    = 16'h0000;
  localparam logic [15:0] OFF_SW     = 16'h0004;
  localparam logic [15:0] OFF_TIMER  = 16'h0008;
  localparam logic [15:0] OFF_CMP    = 16'h000C;
  localparam logic [15:0] OFF_STATUS = 16'h0010;

  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_t;

  // A request with no byte enables set is a read.
  function automatic req_t req_type(input logic [3:0] we);
    return (we == 4'b0000) ? REQ_RD : REQ_WR;
  endfunction

endpackage

// File: rtl/dsram_mmio_regs.sv
// MMIO page registers: LED, synchronised switches, free-running timer, compare, sticky IRQ.
// Read mux is combinational (registered by the parent); writes take effect at the next edge, never stall.
module dsram_mmio_regs
  import dsram_pkg::*;
#(
  parameter int SW_W  = 8,
  parameter int LED_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [15:0]      off,
  input  logic [31:0]      wdata,
  input  logic [SW_W-1:0]  switch_in,
  output logic [31:0]      rd_data,
  output logic [LED_W-1:0] led_out,
  output logic             timer_irq
);

  logic [LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0]  sw_meta_q, sw_meta_d;
  logic [SW_W-1:0]  sw_sync_q, sw_sync_d;
  logic [31:0]      timer_q, timer_d;
  logic [31:0]      cmp_q, cmp_d;
  logic             irq_q, irq_d;

  always_comb begin
    led_d     = led_q;
    sw_meta_d = switch_in;
    sw_sync_d = sw_meta_q;
    timer_d   = timer_q + 32'd1;
    cmp_d     = cmp_q;
    irq_d     = irq_q;
    if (wr_en) begin
      case (off)
        OFF_LED:    led_d   = wdata[LED_W-1:0];
        OFF_TIMER:  timer_d = wdata;
        OFF_CMP:    cmp_d   = wdata;
        OFF_STATUS: if (wdata[0]) irq_d = 1'b0;
        default:    ;
      endcase
    end
    // Compare on the pre-increment value; a match overrides a same-cycle clear.
    if (timer_q == cmp_q) irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      timer_q   <= '0;
      cmp_q     <= CMP_RST;
      irq_q     <= 1'b0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      timer_q   <= timer_d;
      cmp_q     <= cmp_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (off)
      OFF_LED:    rd_data[LED_W-1:0] = led_q;
      OFF_SW:     rd_data[SW_W-1:0]  = sw_sync_q;
      OFF_TIMER:  rd_data            = timer_q;
      OFF_CMP:    rd_data            = cmp_q;
      OFF_STATUS: rd_data[0]         = irq_q;
      default:    ;
    endcase
  end

  assign led_out   = led_q;
  assign timer_irq = irq_q;

endmodule

// File: rtl/data_sram_responder.sv
// Slave end of the CPU data-SRAM port: word RAM plus one MMIO page, always ready.
// Read data appears one cycle after the request and holds until the next read.
module data_sram_responder
  import dsram_pkg::*;
#(
  parameter int          ADDR_W    = 14,
  parameter logic [15:0] MMIO_PAGE = 16'hBFAF,
  parameter int          SW_W      = 8,
  parameter int          LED_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_we,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  input  logic [SW_W-1:0]  switch_in,
  output logic [LED_W-1:0] led_out,
  output logic             timer_irq
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic              is_mmio;
  logic              rd_req;
  logic              wr_req;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       mmio_rdata;
  logic [31:0]       rdata_q, rdata_d;

  assign is_mmio  = (data_sram_addr[31:16] == MMIO_PAGE);
  assign word_idx = data_sram_addr[ADDR_W+1:2];
  assign rd_req   = data_sram_en && (req_type(data_sram_we) == REQ_RD);
  assign wr_req   = data_sram_en && (req_type(data_sram_we) == REQ_WR);

  dsram_mmio_regs #(
    .SW_W  (SW_W),
    .LED_W (LED_W)
  ) u_mmio (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en     (wr_req && is_mmio),
    .off       (data_sram_addr[15:0]),
    .wdata     (data_sram_wdata),
    .switch_in (switch_in),
    .rd_data   (mmio_rdata),
    .led_out   (led_out),
    .timer_irq (timer_irq)
  );

  // RAM contents survive reset; requests seen while in reset are dropped.
  always_ff @(posedge clk) begin
    if (resetn && wr_req && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_req) rdata_d = is_mmio ? mmio_rdata : mem[word_idx];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomised and directed bench for data_sram_responder against a behavioural model.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  sw = 8'h00;
  logic [15:0] led;
  logic        irq;

  always #5 clk = ~clk;

  data_sram_responder dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch_in       (sw),
    .led_out         (led),
    .timer_irq       (irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: RAM as sparse word map, timer as value + elapsed edges.
  logic [31:0] m_mem [int];
  logic [31:0] m_rdata, m_cmp, tw_val;
  int unsigned cyc, tw_cycle;
  logic [15:0] m_led;
  logic [7:0]  m_sw1, m_sw2;
  logic        m_irq;

  localparam logic [31:0] MMIO = 32'hBFAF_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_timer();
    return tw_val + 32'(cyc - tw_cycle);
  endfunction

  task automatic model_reset();
    m_rdata = 32'h0; m_led = 16'h0; m_cmp = 32'hFFFF_FFFF; m_irq = 1'b0;
    m_sw1 = 8'h0; m_sw2 = 8'h0; tw_val = 32'h0; tw_cycle = cyc;
  endtask

  task automatic model_edge();
    logic [31:0] t, w;
    logic        rd, wr, mmio, nirq;
    logic [15:0] off;
    int          idx;
    t    = m_timer();
    rd   = en && (we == 4'h0);
    wr   = en && (we != 4'h0);
    mmio = (addr[31:16] == 16'hBFAF);
    off  = addr[15:0];
    idx  = int'((addr >> 2) % 16384);
    if (rd) begin
      if (!mmio) m_rdata = m_mem[idx];
      else begin
        case (off)
          16'h0000: m_rdata = {16'h0, m_led};
          16'h0004: m_rdata = {24'h0, m_sw2};
          16'h0008: m_rdata = t;
          16'h000C: m_rdata = m_cmp;
          16'h0010: m_rdata = {31'h0, m_irq};
          default:  m_rdata = 32'h0;
        endcase
      end
    end
    nirq = m_irq;
    if (wr && mmio && off == 16'h0010 && wdata[0]) nirq = 1'b0;
    if (t == m_cmp) nirq = 1'b1;
    m_irq = nirq;
    cyc++;
    if (wr && !mmio) begin
      w = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
      for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = wdata[8*i +: 8];
      m_mem[idx] = w;
    end
    if (wr && mmio) begin
      case (off)
        16'h0000: m_led = wdata[15:0];
        16'h0008: begin tw_val = wdata; tw_cycle = cyc; end
        16'h000C: m_cmp = wdata;
        default:  ;
      endcase
    end
    m_sw2 = m_sw1;
    m_sw1 = sw;
  endtask

  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; we = w; addr = a; wdata = d;
    @(posedge clk);
    model_edge();
    #1;
    check("rdata", rdata, m_rdata);
    check("led_out", {16'h0, led}, {16'h0, m_led});
    check("timer_irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  initial begin
    logic [31:0] t_now, a, d;
    logic [3:0]  w;
    int          kind;
    logic [15:0] offs [7];
    offs = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014, 16'h0020};
    cyc = 0;
    model_reset();

    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    #12 resetn = 1'b1;

    // Timer reads 0 in the first cycle after reset release.
    step(1, 4'h0, MMIO | 32'h8, 0);
    check("timer_after_reset", rdata, 32'h0);

    // Full write then read.
    step(1, 4'hF, 32'h0000_0100, 32'h1234_5678);
    step(1, 4'h0, 32'h0000_0100, 0);
    check("t1_read", rdata, 32'h1234_5678);

    // Byte-lane merge.
    step(1, 4'hF, 32'h0000_0104, 32'hAABB_CCDD);
    step(1, 4'b0010, 32'h0000_0104, 32'h0000_EE00);
    step(1, 4'h0, 32'h0000_0104, 0);
    check("t2_lane_merge", rdata, 32'hAABB_EEDD);

    // rdata holds across idle and write cycles.
    step(1, 4'h0, 32'h0000_0100, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 4'h0, 32'h0, 0);
      check("t3_hold", rdata, 32'h1234_5678);
    end
    step(1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
    check("t3_hold_on_write", rdata, 32'h1234_5678);
    step(1, 4'h0, 32'h0001_0100, 0);
    check("t3_alias_read", rdata, 32'hDEAD_BEEF);

    // Timer wrap, compare match, W1C, and set-beats-clear.
    step(1, 4'hF, MMIO | 32'h8, 32'hFFFF_FFFE);
    step(1, 4'hF, MMIO | 32'hC, 32'h0);
    for (int i = 0; i < 4; i++) step(0, 4'h0, 32'h0, 0);
    check("t4_irq_set", {31'h0, irq}, 32'h1);
    step(1, 4'hF, MMIO | 32'h10, 32'h1);
    check("t4_irq_w1c", {31'h0, irq}, 32'h0);
    t_now = m_timer();
    step(1, 4'hF, MMIO | 32'hC, t_now + 32'd3);
    step(0, 4'h0, 32'h0, 0);
    step(0, 4'h0, 32'h0, 0);
    step(1, 4'hF, MMIO | 32'h10, 32'h1);
    check("t4_set_wins", {31'h0, irq}, 32'h1);

    // Switch synchroniser latency, LED width, unmapped offset.
    sw = 8'h5A;
    step(1, 4'h0, MMIO | 32'h4, 0);
    check("t5_sw_0clk", rdata, 32'h0);
    step(1, 4'h0, MMIO | 32'h4, 0);
    check("t5_sw_1clk", rdata, 32'h0);
    step(1, 4'h0, MMIO | 32'h4, 0);
    check("t5_sw_2clk", rdata, 32'h5A);
    step(1, 4'hF, MMIO, 32'hFFFF_FFFF);
    check("t5_led_out", {16'h0, led}, 32'h0000_FFFF);
    step(1, 4'h0, MMIO, 0);
    check("t5_led_read", rdata, 32'h0000_FFFF);
    step(1, 4'h0, MMIO | 32'h20, 0);
    check("t5_unmapped", rdata, 32'h0);

    // Reset between a read request and its response.
    en = 1'b1; we = 4'h0; addr = 32'h0000_0100;
    #2 resetn = 1'b0;
    #1;
    check("t6_rdata", rdata, 32'h0);
    check("t6_led", {16'h0, led}, 32'h0);
    check("t6_irq", {31'h0, irq}, 32'h0);
    model_reset();
    @(posedge clk);
    #3;
    en = 1'b0;
    resetn = 1'b1;
    step(1, 4'h0, 32'h0000_0100, 0);
    check("t6_ram_kept", rdata, 32'hDEAD_BEEF);

    for (int i = 0; i < 16; i++) step(1, 4'hF, 32'h100 + 32'(4 * i), $urandom);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 4) == 0) sw = 8'($urandom);
      kind = $urandom_range(0, 9);
      w = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
      d = $urandom;
      if (kind < 2) step(0, 4'($urandom), $urandom, $urandom);
      else if (kind < 6) begin
        a = 32'h100 + 32'(4 * $urandom_range(0, 15));
        if ($urandom_range(0, 1)) a = a | 32'h0003_0000;
        step(1, w, a, d);
      end else begin
        a = MMIO | {16'h0, offs[$urandom_range(0, 6)]};
        step(1, w, a, d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
